// File: rtl/ex_div.sv
// Execute-stage integer divider: 32-iteration restoring radix-2 divide for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow are answered at start without iterating.
module ex_div (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        rem_op;
  logic        neg_q;
  logic        neg_r;

  logic        is_signed;
  logic        dividend_neg;
  logic        divisor_neg;
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic        div_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_result;

  // op_i[1] selects remainder, op_i[0] selects unsigned
  assign is_signed      = ~op_i[0];
  assign dividend_neg   = is_signed & dividend_i[31];
  assign divisor_neg    = is_signed & divisor_i[31];
  assign dividend_mag   = dividend_neg ? (~dividend_i + 32'd1) : dividend_i;
  assign divisor_mag    = divisor_neg  ? (~divisor_i  + 32'd1) : divisor_i;
  assign div_zero       = (divisor_i == 32'd0);
  assign overflow       = is_signed && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
  assign special        = div_zero | overflow;
  assign special_result = div_zero ? (op_i[1] ? dividend_i : 32'hFFFF_FFFF)
                                   : (op_i[1] ? 32'd0      : 32'h8000_0000);

  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] next_rem;
  logic [31:0] next_quo;
  logic [31:0] q_out;
  logic [31:0] r_out;

  // quo starts holding the dividend magnitude; its MSB feeds the partial remainder each step
  assign shifted  = {rem, quo[31]};
  assign diff     = shifted - {1'b0, dvsr};
  assign next_rem = diff[32] ? shifted[31:0] : diff[31:0];
  assign next_quo = {quo[30:0], ~diff[32]};
  assign q_out    = neg_q ? (~next_quo + 32'd1) : next_quo;
  assign r_out    = neg_r ? (~next_rem + 32'd1) : next_rem;

  assign busy_o = ((state == IDLE) && start_i) || (state == CALC);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state    <= IDLE;
      count    <= 5'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvsr     <= 32'd0;
      rem_op   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 32'd0;
      ready_o  <= 1'b0;
    end else if (flush_i) begin
      state    <= IDLE;
      count    <= 5'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvsr     <= 32'd0;
      result_o <= 32'd0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i) begin
            rem_op <= op_i[1];
            neg_q  <= is_signed & (dividend_i[31] ^ divisor_i[31]);
            neg_r  <= dividend_neg;
            count  <= 5'd0;
            if (special) begin
              result_o <= special_result;
              ready_o  <= 1'b1;
              state    <= DONE;
            end else begin
              rem   <= 32'd0;
              quo   <= dividend_mag;
              dvsr  <= divisor_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= next_rem;
          quo   <= next_quo;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            result_o <= rem_op ? r_out : q_out;
            ready_o  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          ready_o <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ready_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Randomized self-checking bench for ex_div against a plain-arithmetic reference model.
module tb_ex_div;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = 32'd0;
  logic [31:0] divisor_i = 32'd0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int compared = 0;
  int mismatched = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  ex_div dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .start_i(start_i), .flush_i(flush_i),
    .op_i(op_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics using the simulator's own signed/unsigned arithmetic
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output bit special);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    special = 1'b0;
    if (b == 32'd0) begin
      special = 1'b1;
      res = op[1] ? a : 32'hFFFF_FFFF;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      special = 1'b1;
      res = op[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      case (op)
        OP_DIV:  res = sa / sb;
        OP_DIVU: res = a / b;
        OP_REM:  res = sa % sb;
        default: res = a % b;
      endcase
    end
  endfunction

  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    bit special;
    bit got;
    int busy_cycles;
    refModel(op, a, b, exp, special);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i = op;
    dividend_i = a;
    divisor_i = b;
    #1 checkOutput({tag, " busy@start"}, {31'd0, busy_o}, 32'd1);
    @(posedge clk_i);
    #1 start_i = 1'b0;
    busy_cycles = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      if (ready_o) got = 1'b1;
      else if (busy_o) busy_cycles++;
    end
    if (!got) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, " result"}, result_o, exp);
      checkOutput({tag, " busy cycles"}, busy_cycles, special ? 32'd1 : 32'd33);
      @(negedge clk_i);
      checkOutput({tag, " ready pulse"}, {31'd0, ready_o}, 32'd0);
      checkOutput({tag, " result held"}, result_o, exp);
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int ready_seen;

    #12;
    checkOutput("reset result", result_o, 32'd0);
    checkOutput("reset ready", {31'd0, ready_o}, 32'd0);
    checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    n_rst_i = 1'b1;

    applyStimulus("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("REMU 7/2", OP_REMU, 32'd7, 32'd2);
    applyStimulus("DIVU max/16", OP_DIVU, 32'hFFFF_FFFF, 32'h10);
    applyStimulus("DIVU 5/0", OP_DIVU, 32'd5, 32'd0);
    applyStimulus("REM 5/0", OP_REM, 32'd5, 32'd0);
    applyStimulus("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus("DIVU big/-1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

    // flush during iteration 10 of a long divide; result_o currently nonzero
    applyStimulus("DIVU pre-flush", OP_DIVU, 32'h1234_5678, 32'd3);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i = OP_DIVU;
    dividend_i = 32'hDEAD_BEEF;
    divisor_i = 32'd5;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    checkOutput("flush result", result_o, 32'd0);
    checkOutput("flush ready", {31'd0, ready_o}, 32'd0);
    checkOutput("flush busy", {31'd0, busy_o}, 32'd0);
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (ready_o) ready_seen++;
    end
    checkOutput("flush no ready", ready_seen, 32'd0);
    applyStimulus("DIVU 100/7", OP_DIVU, 32'd100, 32'd7);

    // asynchronous reset in the middle of CALC
    @(negedge clk_i);
    start_i = 1'b1;
    op_i = OP_DIV;
    dividend_i = 32'd1000;
    divisor_i = 32'd7;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 n_rst_i = 1'b0;
    #1;
    checkOutput("async rst result", result_o, 32'd0);
    checkOutput("async rst ready", {31'd0, ready_o}, 32'd0);
    checkOutput("async rst busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    n_rst_i = 1'b1;
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (ready_o) ready_seen++;
    end
    checkOutput("rst no pending", ready_seen, 32'd0);

    applyStimulus("DIVU 9/3", OP_DIVU, 32'd9, 32'd3);
    applyStimulus("REMU 9/4", OP_REMU, 32'd9, 32'd4);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = -$urandom_range(1, 100);
        default: rb = $urandom;
      endcase
      applyStimulus($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
